// File: rtl/spi_peripheral_pkg.sv
// Shared FSM state type and debug encodings for the SPI peripheral.
package spi_peripheral_pkg;

  localparam logic [2:0] DBG_IDLE  = 3'd0;
  localparam logic [2:0] DBG_LOAD  = 3'd1;
  localparam logic [2:0] DBG_SHIFT = 3'd2;
  localparam logic [2:0] DBG_ABORT = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = DBG_IDLE,
    ST_LOAD  = DBG_LOAD,
    ST_SHIFT = DBG_SHIFT,
    ST_ABORT = DBG_ABORT
  } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin with edge detection
// taken from the synchronised level and a one-cycle history copy.
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   last_r;

  // synchroniser chain plus history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
      last_r <= RESET_LEVEL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      last_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = sync_r[SYNC_STAGES-1] & ~last_r;
  assign fall  = ~sync_r[SYNC_STAGES-1] & last_r;

endmodule

// File: rtl/spi_peripheral_interface.sv
// Mode-0 SPI target, oversampled in the system clock domain, with a one-deep
// transmit holding register and word-level valid/ready user ports.
module spi_peripheral_interface
  import spi_peripheral_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    SYNC_STAGES  = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = {DATA_WIDTH{1'b0}}
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  spi_clk,
  input  logic                  cs_b,
  input  logic                  pico,
  output logic                  poci,
  output logic                  poci_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic [2:0]            dbg_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic clk;
  logic rst;
  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESET;

  logic sck_level_unused, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic pico_level, pico_rise_unused, pico_fall_unused;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(spi_clk),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_b),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_pico (
    .clk(clk), .rst(rst), .din(pico),
    .level(pico_level), .rise(pico_rise_unused), .fall(pico_fall_unused)
  );

  state_t                  state_r, state_nxt;
  logic [DATA_WIDTH-1:0]   tx_shift_r, tx_shift_nxt;
  logic [DATA_WIDTH-1:0]   rx_shift_r, rx_shift_nxt;
  logic [CNT_W-1:0]        bit_cnt_r, bit_cnt_nxt, cnt_rise_s;
  logic                    word_done_r, word_done_nxt;
  logic [DATA_WIDTH-1:0]   hold_r, hold_nxt;
  logic                    tx_ready_r, tx_ready_nxt;
  logic [DATA_WIDTH-1:0]   rx_data_r, rx_data_nxt;
  logic                    rx_valid_r, rx_valid_nxt;
  logic                    tx_underrun_r, tx_underrun_nxt;
  logic                    frame_abort_r, frame_abort_nxt;
  logic                    poci_r, poci_nxt;
  logic                    poci_oe_r, poci_oe_nxt;
  logic                    last_bit_s, reload_s, accept_s;

  // bit counter value after a rising edge; wraps to zero on the final bit
  always_comb begin
    last_bit_s = (bit_cnt_r == CNT_W'(DATA_WIDTH - 1));
    if (!sck_rise) begin
      cnt_rise_s = bit_cnt_r;
    end else if (last_bit_s) begin
      cnt_rise_s = {CNT_W{1'b0}};
    end else begin
      cnt_rise_s = bit_cnt_r + CNT_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next state; a rise coinciding with cs_rise is counted before the decision
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall) state_nxt = ST_LOAD;
        else         state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (cs_rise) state_nxt = ST_IDLE;
        else         state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cs_rise && (cnt_rise_s == {CNT_W{1'b0}})) state_nxt = ST_IDLE;
        else if (cs_rise)                             state_nxt = ST_ABORT;
        else                                          state_nxt = ST_SHIFT;
      end
      ST_ABORT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    tx_shift_nxt    = tx_shift_r;
    rx_shift_nxt    = rx_shift_r;
    bit_cnt_nxt     = bit_cnt_r;
    word_done_nxt   = word_done_r;
    rx_data_nxt     = rx_data_r;
    rx_valid_nxt    = 1'b0;
    tx_underrun_nxt = 1'b0;
    frame_abort_nxt = 1'b0;
    reload_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bit_cnt_nxt   = {CNT_W{1'b0}};
        word_done_nxt = 1'b0;
      end
      ST_LOAD: begin
        reload_s      = 1'b1;
        bit_cnt_nxt   = {CNT_W{1'b0}};
        word_done_nxt = 1'b0;
      end
      ST_SHIFT: begin
        bit_cnt_nxt = cnt_rise_s;
        if (sck_rise) begin
          rx_shift_nxt = {rx_shift_r[DATA_WIDTH-2:0], pico_level};
          if (last_bit_s) begin
            rx_data_nxt   = {rx_shift_r[DATA_WIDTH-2:0], pico_level};
            rx_valid_nxt  = 1'b1;
            word_done_nxt = 1'b1;
          end else begin
            word_done_nxt = word_done_r;
          end
        end else begin
          rx_shift_nxt = rx_shift_r;
        end
        if (sck_fall && word_done_r) begin
          reload_s      = 1'b1;
          word_done_nxt = 1'b0;
        end else if (sck_fall) begin
          tx_shift_nxt = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
        end else begin
          tx_shift_nxt = tx_shift_r;
        end
        if (cs_rise && (cnt_rise_s != {CNT_W{1'b0}})) begin
          frame_abort_nxt = 1'b1;
        end else begin
          frame_abort_nxt = 1'b0;
        end
      end
      ST_ABORT: begin
        bit_cnt_nxt   = {CNT_W{1'b0}};
        word_done_nxt = 1'b0;
      end
      default: begin
        bit_cnt_nxt   = {CNT_W{1'b0}};
        word_done_nxt = 1'b0;
      end
    endcase

    // a reload always sees the holding register as it was before this cycle's write
    if (reload_s && !tx_ready_r) begin
      tx_shift_nxt = hold_r;
    end else if (reload_s) begin
      tx_shift_nxt    = TX_IDLE_WORD;
      tx_underrun_nxt = 1'b1;
    end else begin
      tx_underrun_nxt = 1'b0;
    end

    accept_s = tx_valid & tx_ready_r;
    if (accept_s) begin
      hold_nxt     = tx_data;
      tx_ready_nxt = 1'b0;
    end else if (reload_s) begin
      hold_nxt     = hold_r;
      tx_ready_nxt = 1'b1;
    end else begin
      hold_nxt     = hold_r;
      tx_ready_nxt = tx_ready_r;
    end

    poci_oe_nxt = ~cs_level;
    poci_nxt    = poci_oe_nxt & tx_shift_nxt[DATA_WIDTH-1];
  end

  // datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_r    <= {DATA_WIDTH{1'b0}};
      rx_shift_r    <= {DATA_WIDTH{1'b0}};
      bit_cnt_r     <= {CNT_W{1'b0}};
      word_done_r   <= 1'b0;
      hold_r        <= {DATA_WIDTH{1'b0}};
      tx_ready_r    <= 1'b1;
      rx_data_r     <= {DATA_WIDTH{1'b0}};
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      frame_abort_r <= 1'b0;
      poci_r        <= 1'b0;
      poci_oe_r     <= 1'b0;
    end else begin
      tx_shift_r    <= tx_shift_nxt;
      rx_shift_r    <= rx_shift_nxt;
      bit_cnt_r     <= bit_cnt_nxt;
      word_done_r   <= word_done_nxt;
      hold_r        <= hold_nxt;
      tx_ready_r    <= tx_ready_nxt;
      rx_data_r     <= rx_data_nxt;
      rx_valid_r    <= rx_valid_nxt;
      tx_underrun_r <= tx_underrun_nxt;
      frame_abort_r <= frame_abort_nxt;
      poci_r        <= poci_nxt;
      poci_oe_r     <= poci_oe_nxt;
    end
  end

  assign poci        = poci_r;
  assign poci_oe     = poci_oe_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_ready    = tx_ready_r;
  assign tx_underrun = tx_underrun_r;
  assign frame_abort = frame_abort_r;
  assign dbg_state   = state_r;

endmodule
